// File: rtl/mips_cpu_data_bus_bridge.sv
// Bridges the MIPS CPU data port (combinational load/store request) onto an Avalon-MM master.
// Latency: a load stalls the CPU 3 cycles and a store 2 cycles, plus one cycle per waitrequest cycle.
// Backpressure: avm_waitrequest holds the request stable; TIMEOUT consecutive waits abandon it and set bus_error.
module mips_cpu_data_bus_bridge #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [3:0]  cpu_data_byteenable,
  input  logic [31:0] cpu_data_address,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        bus_error,
  output logic [31:0] stall_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  be_q;
  logic        op_read_q;
  logic [31:0] wait_cnt;
  logic        req;
  logic        in_req;
  logic        timeout_hit;

  assign req = (cpu_data_read | cpu_data_write) & cpu_active;

  // Gating with reset lets a mid-transaction reset drop the strobes without waiting for state to settle.
  assign in_req      = (state == S_REQ) & reset;
  assign timeout_hit = in_req & avm_waitrequest & (wait_cnt == 32'(TIMEOUT - 1));

  assign avm_read          = in_req & op_read_q;
  assign avm_write         = in_req & ~op_read_q;
  assign avm_byteenable    = in_req ? be_q : 4'b0000;
  assign avm_address       = addr_q;
  assign avm_writedata     = wdata_q;
  assign cpu_data_readdata = rdata_q;

  // CPU runs freely in IDLE when there is no memory access, and for the single commit cycle in DONE.
  always_comb begin
    cpu_clk_enable = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE:  cpu_clk_enable = ~req;
        S_DONE:  cpu_clk_enable = 1'b1;
        default: cpu_clk_enable = 1'b0;
      endcase
    end
  end

  // Transaction FSM: latch request in IDLE, hold it on the bus in REQ, capture load data in RDATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      op_read_q <= 1'b0;
      rdata_q   <= 32'd0;
      wait_cnt  <= 32'd0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= 32'd0;
          if (req) begin
            addr_q    <= cpu_data_address & 32'hFFFF_FFFC;
            wdata_q   <= cpu_data_writedata;
            be_q      <= cpu_data_byteenable;
            op_read_q <= cpu_data_read;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (timeout_hit) begin
            bus_error <= 1'b1;
            rdata_q   <= 32'd0;
            wait_cnt  <= 32'd0;
            state     <= S_DONE;
          end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt + 32'd1;
          end else begin
            wait_cnt <= 32'd0;
            state    <= op_read_q ? S_RDATA : S_DONE;
          end
        end
        S_RDATA: begin
          rdata_q <= avm_readdata;
          state   <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running count of CPU stall cycles, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 32'd0;
    end else if (!cpu_clk_enable) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
